// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter state encoding, command bytes,
// frame geometry and the odd-parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    SEND,
    ACK,
    WAIT_IDLE
  } ps2_tx_state_t;

  localparam logic [7:0] PS2_CMD_SETLED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_CMD_ECHO   = 8'hEE;

  // data[7:0] + parity + stop; the start bit is driven before clock release
  localparam int unsigned PS2_FRAME_BITS = 10;

  function automatic logic ps2_odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// One PS/2 line: 2-FF synchronizer, 3-sample majority filter and a
// one-cycle strobe on each filtered 1->0 transition.
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic fall
);

  logic [1:0] sync_q;
  logic [2:0] hist_q;
  logic       maj;

  assign maj = (hist_q[0] & hist_q[1]) |
               (hist_q[0] & hist_q[2]) |
               (hist_q[1] & hist_q[2]);

  // Idle bus is pulled high, so every stage resets to 1
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
      hist_q <= '1;
      level  <= 1'b1;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pin};
      hist_q <= {hist_q[1:0], sync_q[1]};
      level  <= maj;
      fall   <= level & ~maj;
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 byte transmitter: inhibit, request-to-send, clocked-out
// frame, ACK check and return-to-idle, with an overall timeout.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 24_000_000,
  parameter int unsigned INHIBIT_US = 120,
  parameter int unsigned TIMEOUT_US = 15_000
) (
  input  logic       clk24,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       rx_inhibit
);

  localparam int unsigned CYC_PER_US  = CLK_HZ / 1_000_000;
  localparam int unsigned INHIBIT_CYC = CYC_PER_US * INHIBIT_US;
  localparam int unsigned TIMEOUT_CYC = CYC_PER_US * TIMEOUT_US;
  localparam int unsigned INH_W       = $clog2(INHIBIT_CYC + 1);
  localparam int unsigned TMO_W       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef logic [INH_W-1:0] inh_t;
  typedef logic [TMO_W-1:0] tmo_t;

  localparam inh_t       INHIBIT_LOAD = inh_t'(INHIBIT_CYC);
  localparam tmo_t       TMO_LAST     = tmo_t'(TIMEOUT_CYC - 1);
  localparam logic [3:0] BIT_LAST     = 4'(PS2_FRAME_BITS - 1);

  ps2_tx_state_t state_q, state_d;
  logic [9:0]    shift_q, shift_d;
  logic [3:0]    bit_q, bit_d;
  inh_t          inh_q, inh_d;
  tmo_t          tmo_q, tmo_d;
  logic          clk_oe_d, dat_oe_d;
  logic          done_d, error_d;
  logic          timed;

  logic          clk_lvl, clk_fall;
  logic          dat_lvl, dat_fall_unused;

  ps2_line_sync u_clk_sync (
    .clk   (clk24),
    .reset (reset),
    .pin   (ps2_clk_i),
    .level (clk_lvl),
    .fall  (clk_fall)
  );

  ps2_line_sync u_dat_sync (
    .clk   (clk24),
    .reset (reset),
    .pin   (ps2_dat_i),
    .level (dat_lvl),
    .fall  (dat_fall_unused)
  );

  // busy stays up through the done/error pulse cycle so a start there is dropped
  assign busy       = (state_q != IDLE) | done | error;
  assign rx_inhibit = busy;
  assign timed      = (state_q == SEND) || (state_q == ACK) || (state_q == WAIT_IDLE);

  always_ff @(posedge clk24) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_q      <= '0;
      inh_q      <= '0;
      tmo_q      <= '0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_q      <= bit_d;
      inh_q      <= inh_d;
      tmo_q      <= tmo_d;
      ps2_clk_oe <= clk_oe_d;
      ps2_dat_oe <= dat_oe_d;
      done       <= done_d;
      error      <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    inh_d    = inh_q;
    tmo_d    = timed ? tmo_q + 1'b1 : tmo_q;
    clk_oe_d = ps2_clk_oe;
    dat_oe_d = ps2_dat_oe;
    done_d   = 1'b0;
    error_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (tx_start && !done && !error) begin
          shift_d  = {1'b1, ps2_odd_parity(tx_data), tx_data};
          bit_d    = '0;
          inh_d    = INHIBIT_LOAD;
          clk_oe_d = 1'b1;
          dat_oe_d = 1'b0;
          state_d  = INHIBIT;
        end
      end

      INHIBIT: begin
        // start bit goes out on the last count so the clock is held exactly INHIBIT_CYC cycles
        if (inh_q != '0) begin
          inh_d = inh_q - 1'b1;
          if (inh_q == inh_t'(1)) dat_oe_d = 1'b1;
        end else begin
          clk_oe_d = 1'b0;
          tmo_d    = '0;
          state_d  = SEND;
        end
      end

      SEND: begin
        if (clk_fall) begin
          dat_oe_d = ~shift_q[0];
          shift_d  = {1'b0, shift_q[9:1]};
          bit_d    = bit_q + 1'b1;
          if (bit_q == BIT_LAST) state_d = ACK;
        end
      end

      ACK: begin
        if (clk_fall) begin
          if (!dat_lvl) begin
            state_d = WAIT_IDLE;
          end else begin
            dat_oe_d = 1'b0;
            error_d  = 1'b1;
            state_d  = IDLE;
          end
        end
      end

      WAIT_IDLE: begin
        if (clk_lvl && dat_lvl) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (timed && tmo_q == TMO_LAST) begin
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
      done_d   = 1'b0;
      error_d  = 1'b1;
      state_d  = IDLE;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboarded bench for ps2_host_tx: a PS/2 device model clocks frames out of
// the host while expected bits and completion events are queued at start time.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned CLK_HZ     = 2_000_000;
  localparam int unsigned INHIBIT_US = 120;
  localparam int unsigned TIMEOUT_US = 5_000;
  localparam int INHIB = int'((CLK_HZ / 1_000_000) * INHIBIT_US);
  localparam int TMO   = int'((CLK_HZ / 1_000_000) * TIMEOUT_US);
  localparam int HALF  = int'(CLK_HZ / 12_500 / 2);

  localparam logic [1:0] EVT_NONE = 2'b00;
  localparam logic [1:0] EVT_DONE = 2'b10;
  localparam logic [1:0] EVT_ERR  = 2'b01;

  logic       clk24 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_start = 1'b0;
  logic       busy, done, error, ps2_clk_oe, ps2_dat_oe, rx_inhibit;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       ps2_clk_i, ps2_dat_i;

  // open-drain bus: low if either side pulls
  assign ps2_clk_i = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_i = dev_dat & ~ps2_dat_oe;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int evt_cyc  = 0;
  int rel_cyc  = 0;
  int ack_cyc  = 0;
  int n_done   = 0;
  int n_err    = 0;
  logic       bits_q[$];
  logic [1:0] evt_q[$];

  ps2_host_tx #(
    .CLK_HZ    (CLK_HZ),
    .INHIBIT_US(INHIBIT_US),
    .TIMEOUT_US(TIMEOUT_US)
  ) dut (
    .clk24     (clk24),
    .reset     (reset),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .ps2_clk_i (ps2_clk_i),
    .ps2_dat_i (ps2_dat_i),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .rx_inhibit(rx_inhibit)
  );

  always #5 clk24 = ~clk24;
  always @(posedge clk24) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk24);
  endtask

  always @(negedge clk24) begin
    if (!reset && (done || error)) begin
      evt_cyc = cyc;
      n_done += int'(done);
      n_err  += int'(error);
      if (evt_q.size() != 0) check("evt", {30'd0, done, error}, {30'd0, evt_q.pop_front()});
      else check("evt_unexpected", {30'd0, done, error}, 32'd0);
    end
  end

  task automatic push_frame(input logic [7:0] d, input logic [1:0] evt);
    for (int k = 0; k < 8; k++) bits_q.push_back(d[k]);
    bits_q.push_back(~^d);
    bits_q.push_back(1'b1);
    if (evt != EVT_NONE) evt_q.push_back(evt);
  endtask

  task automatic start_tx(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    step(1);
    tx_start = 1'b0;
  endtask

  task automatic run_inhibit();
    int n;
    check("start_busy", {31'd0, busy}, 32'd1);
    check("rx_inh_eq_busy", {31'd0, rx_inhibit}, {31'd0, busy});
    check("start_clk_oe", {31'd0, ps2_clk_oe}, 32'd1);
    n = 0;
    while (!ps2_dat_oe && n < INHIB + 50) begin
      step(1);
      n++;
    end
    check("inhibit_len", n, INHIB);
    check("inhibit_clk_hold", {31'd0, ps2_clk_oe}, 32'd1);
    step(1);
    check("clk_release", {31'd0, ps2_clk_oe}, 32'd0);
    rel_cyc = cyc;
  endtask

  task automatic dev_frame(input bit ack, input int poke_bit, input int rst_bit);
    for (int k = 0; k < 10; k++) begin
      step(HALF);
      dev_clk = 1'b0;
      step(HALF);
      if (bits_q.size() != 0) check($sformatf("bit%0d", k), {31'd0, ps2_dat_i}, {31'd0, bits_q.pop_front()});
      else check("bitq_empty", bits_q.size(), 1);
      if (k == rst_bit) begin
        reset = 1'b1;
        step(1);
        check("rst_mid_outs", {27'd0, ps2_clk_oe, ps2_dat_oe, busy, done, error}, 32'd0);
        reset   = 1'b0;
        dev_clk = 1'b1;
        bits_q.delete();
        return;
      end
      if (k == poke_bit) begin
        tx_data  = 8'h00;
        tx_start = 1'b1;
        step(1);
        tx_start = 1'b0;
        check("poke_busy", {31'd0, busy}, 32'd1);
      end
      dev_clk = 1'b1;
    end
    step(HALF / 2);
    dev_dat = ack ? 1'b0 : 1'b1;
    step(HALF / 2);
    dev_clk = 1'b0;
    ack_cyc = cyc;
    step(HALF);
    dev_clk = 1'b1;
    step(HALF / 2);
    dev_dat = 1'b1;
  endtask

  task automatic wait_evt(input string tag, input int bound);
    int n;
    n = 0;
    while (evt_q.size() != 0 && n < bound) begin
      step(1);
      n++;
    end
    check(tag, evt_q.size(), 0);
    evt_q.delete();
  endtask

  initial begin
    int base;
    reset = 1'b1;
    step(3);
    check("reset_outs", {26'd0, busy, done, error, ps2_clk_oe, ps2_dat_oe, rx_inhibit}, 32'd0);
    reset = 1'b0;
    step(2);

    push_frame(PS2_CMD_SETLED, EVT_DONE);
    start_tx(PS2_CMD_SETLED);
    run_inhibit();
    dev_frame(1'b1, -1, -1);
    wait_evt("setled_done", 2000);
    step(1);
    check("setled_idle", {29'd0, busy, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    check("setled_ndone", n_done, 1);

    push_frame(8'h01, EVT_DONE);
    start_tx(8'h01);
    run_inhibit();
    dev_frame(1'b1, -1, -1);
    wait_evt("x01_done", 2000);
    check("x01_ndone", n_done, 2);

    push_frame(PS2_CMD_ECHO, EVT_ERR);
    start_tx(PS2_CMD_ECHO);
    run_inhibit();
    dev_frame(1'b0, -1, -1);
    wait_evt("nack_err", 2000);
    check("nack_latency_ok", {31'd0, (evt_cyc - ack_cyc >= 1) && (evt_cyc - ack_cyc <= 10)}, 32'd1);
    step(1);
    check("nack_idle", {30'd0, busy, ps2_clk_oe}, 32'd0);
    check("nack_ndone", n_done, 2);

    push_frame(PS2_CMD_RESET, EVT_DONE);
    start_tx(PS2_CMD_RESET);
    run_inhibit();
    dev_frame(1'b1, 4, -1);
    wait_evt("poke_done", 2000);
    step(4 * HALF);
    check("poke_ndone", n_done, 3);
    check("poke_idle", {31'd0, busy}, 32'd0);

    base = n_done + n_err;
    push_frame(PS2_CMD_SETLED, EVT_NONE);
    start_tx(PS2_CMD_SETLED);
    run_inhibit();
    dev_frame(1'b1, -1, 6);
    step(4 * HALF);
    check("rst_no_evt", n_done + n_err, base);
    push_frame(8'h01, EVT_DONE);
    start_tx(8'h01);
    run_inhibit();
    dev_frame(1'b1, -1, -1);
    wait_evt("after_rst_done", 2000);
    check("after_rst_ndone", n_done, 4);

    evt_q.push_back(EVT_ERR);
    start_tx(PS2_CMD_RESET);
    run_inhibit();
    wait_evt("tmo_err", TMO + 100);
    check("tmo_latency", evt_cyc - rel_cyc, TMO);
    step(1);
    check("tmo_idle", {29'd0, busy, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    check("tmo_ndone", n_done, 4);

    check("bits_left", bits_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It is the send side that pairs with the existing PS/2 keyboard receive path.
- Sends single command/data bytes to the keyboard, e.g. 0xED set-LEDs with the RUS/LAT and CAPS indicator byte, or 0xFF reset.
- Drives PS2_CLK/PS2_DAT as open-drain through output-enable pins, and tells the receive path to ignore the bus while a frame is in flight.

Parameters:
- CLK_HZ, 24000000, frequency of clk24 in Hz.
- INHIBIT_US, 120, time the host holds the clock low before request-to-send.
- TIMEOUT_US, 15000, maximum time from clock release to ACK completion.

Ports:
- clk24  in  1  system clock, single clock domain.
- reset  in  1  synchronous reset, active-high.
- tx_data  in  8  byte to send; latched on an accepted tx_start.
- tx_start  in  1  one-cycle request; accepted only when busy=0.
- busy  out  1  high from the accepted start until return to IDLE.
- done  out  1  one-cycle pulse: frame sent and device ACKed.
- error  out  1  one-cycle pulse: timeout or missing ACK.
- ps2_clk_i  in  1  raw PS2_CLK pin level (asynchronous).
- ps2_dat_i  in  1  raw PS2_DAT pin level (asynchronous).
- ps2_clk_oe  out  1  1 = pull PS2_CLK low; 0 = release.
- ps2_dat_oe  out  1  1 = pull PS2_DAT low; 0 = release.
- rx_inhibit  out  1  equals busy; the receiver discards frames while it is high.

Behaviour:
- Reset: all outputs 0, state IDLE, both lines released. Reset mid-frame releases both lines on the next clk24 edge with no done/error pulse.
- Input conditioning: ps2_clk_i and ps2_dat_i pass through a 2-FF synchronizer, then a 3-sample majority filter. A falling edge is filtered 1 then 0.
- Parity: odd, equal to ~^tx_data.
- Shift register: 10 bits, {stop=1, parity, data[7:0]}, sent LSB first.
- IDLE:
  - tx_start=1 → latch tx_data, busy=1, clk_oe=1, load the inhibit counter with CLK_HZ/1e6*INHIBIT_US (2880 at defaults), go to INHIBIT.
  - tx_start while busy is ignored and not queued.
- INHIBIT: count down. At 0: dat_oe=1 (start bit), then one cycle later clk_oe=0. Clear the timeout counter and go to SEND.
- SEND:
  - On each filtered clock falling edge k=0..9, set dat_oe = ~shift[k].
  - The stop bit (k=9) releases data.
  - After edge 9, go to ACK.
- ACK:
  - On the next falling edge, sample data. Data=0 → WAIT_IDLE. Data=1 → error pulse, go to IDLE.
- WAIT_IDLE: wait until the filtered clk=1 and dat=1 together, then done pulse, busy=0, IDLE.
- Timeout:
  - Counter runs in SEND, ACK and WAIT_IDLE, limit CLK_HZ/1e6*TIMEOUT_US (360000, 19 bits).
  - Reaching the limit: release both lines, error pulse, IDLE.
- done and error are mutually exclusive and never asserted in the same cycle.
- A device falling edge during INHIBIT is ignored because clk is held low.
- tx_start in the same cycle that done/error pulses is ignored, since busy is still 1. It is accepted from the next cycle on.

Decomposition:
- Package ps2_pkg holds:
  - state encoding: IDLE, INHIBIT, SEND, ACK, WAIT_IDLE;
  - command constants PS2_CMD_SETLED=8'hED, PS2_CMD_RESET=8'hFF, PS2_CMD_ECHO=8'hEE;
  - frame length constant 10.
- Sub-module ps2_line_sync handles synchronizer, majority filter and fall-edge strobe per line. It is shared with the receiver.

Test Plan:
- tx_data=8'hED with a device model clocking at 12.5 kHz:
  - clk_oe is low for exactly 2880 cycles, then dat_oe=1;
  - bits on the 10 falling edges are 1,0,1,1,0,1,1,1, parity=1, stop released;
  - device ACK → done pulses once, busy falls.
- tx_data=8'h01 → parity bit 0 observed on falling edge 8; otherwise the same as above.
- Device never clocks after release → error pulses at 360000 cycles after clock release, both oe=0, done never asserted.
- Device leaves data high on the ACK edge → error pulse on the cycle after that edge, state IDLE.
- tx_start pulsed again at bit 4 of a frame → ignored; only one frame is sent and one done pulse appears.
- reset asserted for one cycle during SEND bit 6 → next cycle clk_oe=dat_oe=busy=0, no done/error pulse; a new tx_start afterwards completes normally.
